// File: rtl/msrv32_dmem_pkg.sv
// Shared types and constants for the RV32 data-memory AHB-Lite interface.
package msrv32_dmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ADDR  = 2'b01,
        DATA  = 2'b10,
        MISAL = 2'b11
    } dmem_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Size code 11 is treated as a word access on the bus.
    function automatic logic [2:0] ahb_hsize(input logic [1:0] size);
        if (size == SIZE_BYTE || size == SIZE_HALF)
            return {1'b0, size};
        else
            return {1'b0, SIZE_WORD};
    endfunction

endpackage

// File: rtl/msrv32_store_lane_gen.sv
// Store-data lane replication and alignment check for a data-memory request.
module msrv32_store_lane_gen
    import msrv32_dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lsb,
    input  logic [31:0] wdata,
    output logic [31:0] lane_wdata,
    output logic        misaligned
);

    always_comb begin
        lane_wdata = wdata;
        misaligned = 1'b0;
        case (size)
            SIZE_BYTE: lane_wdata = {4{wdata[7:0]}};
            SIZE_HALF: begin
                lane_wdata = {2{wdata[15:0]}};
                misaligned = addr_lsb[0];
            end
            default:   misaligned = |addr_lsb;
        endcase
    end

endmodule

// File: rtl/msrv32_dmem_ahb_if.sv
// Runs one load/store request as a single AHB-Lite transfer and returns the
// registered response, plus lane-extraction metadata, to the load unit.
module msrv32_dmem_ahb_if
    import msrv32_dmem_pkg::*;
(
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_write_in,
    input  logic [31:0] req_addr_in,
    input  logic [1:0]  req_size_in,
    input  logic        req_unsigned_in,
    input  logic [31:0] req_wdata_in,
    output logic [31:0] ms_riscv32_mp_dmaddr_out,
    output logic [1:0]  ms_riscv32_mp_htrans_out,
    output logic        ms_riscv32_mp_hwrite_out,
    output logic [2:0]  ms_riscv32_mp_hsize_out,
    output logic [31:0] ms_riscv32_mp_dmwr_data_out,
    input  logic        ms_riscv32_mp_hready_in,
    input  logic        ms_riscv32_mp_hresp_in,
    input  logic [31:0] ms_riscv32_mp_dmdata_in,
    output logic        rsp_valid_out,
    output logic [31:0] ms_riscv32_mp_dmdata_out,
    output logic        ahb_resp_out,
    output logic        misaligned_out,
    output logic [1:0]  iadder_out_1_0_out,
    output logic [1:0]  load_size_out,
    output logic        load_unsigned_out,
    output logic        lsu_stall_out
);

    dmem_state_e state, next_state;

    logic [31:0] lane_wdata;
    logic        lane_misaligned;
    logic [1:0]  size_q;
    logic        unsigned_q;

    msrv32_store_lane_gen u_lane_gen (
        .size       (req_size_in),
        .addr_lsb   (req_addr_in[1:0]),
        .wdata      (req_wdata_in),
        .lane_wdata (lane_wdata),
        .misaligned (lane_misaligned)
    );

    assign req_ready_out = (state == IDLE);
    assign lsu_stall_out = (state != IDLE);

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid_in) next_state = lane_misaligned ? MISAL : ADDR;
            ADDR:    if (ms_riscv32_mp_hready_in) next_state = DATA;
            DATA:    if (ms_riscv32_mp_hready_in) next_state = IDLE;
            MISAL:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The bus address-phase registers double as the request record, so HADDR,
    // HWRITE and HSIZE stay stable through address-phase wait states.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            ms_riscv32_mp_dmaddr_out    <= 32'd0;
            ms_riscv32_mp_htrans_out    <= HTRANS_IDLE;
            ms_riscv32_mp_hwrite_out    <= 1'b0;
            ms_riscv32_mp_hsize_out     <= 3'd0;
            ms_riscv32_mp_dmwr_data_out <= 32'd0;
            size_q                      <= 2'd0;
            unsigned_q                  <= 1'b0;
            rsp_valid_out               <= 1'b0;
            ms_riscv32_mp_dmdata_out    <= 32'd0;
            ahb_resp_out                <= 1'b0;
            misaligned_out              <= 1'b0;
            iadder_out_1_0_out          <= 2'd0;
            load_size_out               <= 2'd0;
            load_unsigned_out           <= 1'b0;
        end else begin
            rsp_valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_in) begin
                        ms_riscv32_mp_dmaddr_out    <= req_addr_in;
                        ms_riscv32_mp_hwrite_out    <= req_write_in;
                        ms_riscv32_mp_hsize_out     <= ahb_hsize(req_size_in);
                        ms_riscv32_mp_dmwr_data_out <= lane_wdata;
                        size_q                      <= req_size_in;
                        unsigned_q                  <= req_unsigned_in;
                        if (!lane_misaligned)
                            ms_riscv32_mp_htrans_out <= HTRANS_NONSEQ;
                    end
                end
                ADDR: begin
                    if (ms_riscv32_mp_hready_in)
                        ms_riscv32_mp_htrans_out <= HTRANS_IDLE;
                end
                DATA: begin
                    if (ms_riscv32_mp_hready_in) begin
                        rsp_valid_out      <= 1'b1;
                        ahb_resp_out       <= ms_riscv32_mp_hresp_in;
                        misaligned_out     <= 1'b0;
                        iadder_out_1_0_out <= ms_riscv32_mp_dmaddr_out[1:0];
                        load_size_out      <= size_q;
                        load_unsigned_out  <= unsigned_q;
                        if (!ms_riscv32_mp_hwrite_out)
                            ms_riscv32_mp_dmdata_out <= ms_riscv32_mp_dmdata_in;
                    end
                end
                MISAL: begin
                    rsp_valid_out      <= 1'b1;
                    ahb_resp_out       <= 1'b1;
                    misaligned_out     <= 1'b1;
                    iadder_out_1_0_out <= ms_riscv32_mp_dmaddr_out[1:0];
                    load_size_out      <= size_q;
                    load_unsigned_out  <= unsigned_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_msrv32_dmem_ahb_if.sv
// Self-checking bench for msrv32_dmem_ahb_if: directed and random transfers
// against a cycle-count/arithmetic reference model with a scripted AHB slave.
module tb_msrv32_dmem_ahb_if;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;
    logic        rsp_valid;
    logic [31:0] dmdata;
    logic        ahb_resp;
    logic        misaligned;
    logic [1:0]  iadder_lsb;
    logic [1:0]  load_size;
    logic        load_unsigned;
    logic        lsu_stall;

    int assert_count = 0;
    int fail_count   = 0;

    logic [31:0] exp_dmdata;
    logic        exp_resp;
    logic        exp_misal;

    msrv32_dmem_ahb_if dut (
        .ms_riscv32_mp_clk_in        (clk),
        .ms_riscv32_mp_rst_in        (rst),
        .req_valid_in                (req_valid),
        .req_ready_out               (req_ready),
        .req_write_in                (req_write),
        .req_addr_in                 (req_addr),
        .req_size_in                 (req_size),
        .req_unsigned_in             (req_unsigned),
        .req_wdata_in                (req_wdata),
        .ms_riscv32_mp_dmaddr_out    (haddr),
        .ms_riscv32_mp_htrans_out    (htrans),
        .ms_riscv32_mp_hwrite_out    (hwrite),
        .ms_riscv32_mp_hsize_out     (hsize),
        .ms_riscv32_mp_dmwr_data_out (hwdata),
        .ms_riscv32_mp_hready_in     (hready),
        .ms_riscv32_mp_hresp_in      (hresp),
        .ms_riscv32_mp_dmdata_in     (hrdata),
        .rsp_valid_out               (rsp_valid),
        .ms_riscv32_mp_dmdata_out    (dmdata),
        .ahb_resp_out                (ahb_resp),
        .misaligned_out              (misaligned),
        .iadder_out_1_0_out          (iadder_lsb),
        .load_size_out               (load_size),
        .load_unsigned_out           (load_unsigned),
        .lsu_stall_out               (lsu_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] model_lanes(input logic [31:0] w, input logic [1:0] s);
        if (s == 2'd0)
            return {24'd0, w[7:0]} * 32'h0101_0101;
        else if (s == 2'd1)
            return {16'd0, w[15:0]} * 32'h0001_0001;
        else
            return w;
    endfunction

    function automatic logic model_misaligned(input logic [31:0] a, input logic [1:0] s);
        int unsigned nbytes;
        nbytes = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        return (a % nbytes) != 0;
    endfunction

    function automatic logic [2:0] model_hsize(input logic [1:0] s);
        return (s == 2'd3) ? 3'd2 : {1'b0, s};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idleCycle(input string tag);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "_htrans"}, 32'(htrans), 32'd0);
        checkOutput({tag, "_stall"}, 32'(lsu_stall), 32'd0);
        checkOutput({tag, "_dmdata_hold"}, dmdata, exp_dmdata);
        checkOutput({tag, "_resp_hold"}, 32'(ahb_resp), 32'(exp_resp));
        checkOutput({tag, "_misal_hold"}, 32'(misaligned), 32'(exp_misal));
    endtask

    // One complete request with a scripted slave: aw/dw wait states in the
    // address/data phase, err selects a two-cycle ERROR response.
    task automatic applyStimulus(input string tag, input logic wr, input logic [31:0] addr,
                                 input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                                 input int aw, input int dw, input logic err, input logic [31:0] rdata);
        logic misal;
        int   lat;
        int   j;
        logic addr_phase;
        logic data_phase;
        misal = model_misaligned(addr, size);
        lat   = misal ? 2 : 3 + aw + dw + (err ? 1 : 0);

        @(posedge clk); #1;
        req_valid    = 1'b1;
        req_write    = wr;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        @(negedge clk);
        checkOutput({tag, "_ready_accept"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid    = 1'b0;
        req_write    = ~wr;
        req_addr     = $urandom;
        req_size     = 2'($urandom);
        req_unsigned = ~uns;
        req_wdata    = $urandom;

        for (int k = 1; k <= lat; k++) begin
            hready = 1'b1;
            hresp  = 1'b0;
            hrdata = $urandom;
            if (!misal && k < lat) begin
                if (k <= aw) begin
                    hready = 1'b0;
                end else if (k > aw + 1) begin
                    j = k - (aw + 1);
                    if (j <= dw) begin
                        hready = 1'b0;
                    end else if (err && j == dw + 1) begin
                        hready = 1'b0;
                        hresp  = 1'b1;
                    end else begin
                        hresp  = err;
                        hrdata = rdata;
                    end
                end
            end
            @(negedge clk);
            addr_phase = !misal && (k <= aw + 1);
            data_phase = !misal && (k > aw + 1) && (k < lat);
            checkOutput($sformatf("%s_htrans_c%0d", tag, k), 32'(htrans), addr_phase ? 32'd2 : 32'd0);
            if (addr_phase) begin
                checkOutput($sformatf("%s_haddr_c%0d", tag, k), haddr, addr);
                checkOutput($sformatf("%s_hwrite_c%0d", tag, k), 32'(hwrite), 32'(wr));
                checkOutput($sformatf("%s_hsize_c%0d", tag, k), 32'(hsize), 32'(model_hsize(size)));
            end
            if (data_phase && wr)
                checkOutput($sformatf("%s_hwdata_c%0d", tag, k), hwdata, model_lanes(wdata, size));
            checkOutput($sformatf("%s_stall_c%0d", tag, k), 32'(lsu_stall), 32'(k < lat));
            checkOutput($sformatf("%s_rsp_valid_c%0d", tag, k), 32'(rsp_valid), 32'(k == lat));
            if (k < lat) begin
                @(posedge clk); #1;
            end
        end

        exp_misal = misal;
        exp_resp  = misal ? 1'b1 : err;
        if (!misal && !wr)
            exp_dmdata = rdata;
        checkOutput({tag, "_dmdata"}, dmdata, exp_dmdata);
        checkOutput({tag, "_ahb_resp"}, 32'(ahb_resp), 32'(exp_resp));
        checkOutput({tag, "_misaligned"}, 32'(misaligned), 32'(exp_misal));
        checkOutput({tag, "_offset"}, 32'(iadder_lsb), addr % 4);
        checkOutput({tag, "_load_size"}, 32'(load_size), 32'(size));
        checkOutput({tag, "_load_unsigned"}, 32'(load_unsigned), 32'(uns));
        checkOutput({tag, "_ready_rsp"}, 32'(req_ready), 32'd1);
        hready = 1'b1;
        hresp  = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = 32'd0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_wdata    = 32'd0;
        hready       = 1'b1;
        hresp        = 1'b0;
        hrdata       = 32'd0;
        exp_dmdata   = 32'd0;
        exp_resp     = 1'b0;
        exp_misal    = 1'b0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_htrans", 32'(htrans), 32'd0);
        checkOutput("reset_haddr", haddr, 32'd0);
        checkOutput("reset_hwrite", 32'(hwrite), 32'd0);
        checkOutput("reset_hsize", 32'(hsize), 32'd0);
        checkOutput("reset_hwdata", hwdata, 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_dmdata", dmdata, 32'd0);
        checkOutput("reset_ahb_resp", 32'(ahb_resp), 32'd0);
        checkOutput("reset_misaligned", 32'(misaligned), 32'd0);
        checkOutput("reset_offset", 32'(iadder_lsb), 32'd0);
        checkOutput("reset_load_size", 32'(load_size), 32'd0);
        checkOutput("reset_load_unsigned", 32'(load_unsigned), 32'd0);
        checkOutput("reset_stall", 32'(lsu_stall), 32'd0);

        applyStimulus("word_load", 1'b0, 32'h0000_1000, 2'b10, 1'b0, 32'h0, 0, 0, 1'b0, 32'hDEAD_BEEF);
        idleCycle("idle1");
        applyStimulus("byte_store", 1'b1, 32'h0000_2003, 2'b00, 1'b0, 32'h0000_00A5, 0, 0, 1'b0, 32'h0);
        idleCycle("idle2");
        applyStimulus("half_load_wait", 1'b0, 32'h0000_3002, 2'b01, 1'b1, 32'h0, 0, 2, 1'b0, 32'h1234_5678);
        idleCycle("idle3");
        applyStimulus("misal_word", 1'b0, 32'h0000_4001, 2'b10, 1'b0, 32'h0, 0, 0, 1'b0, 32'hCAFE_F00D);
        idleCycle("idle4");
        applyStimulus("error_load", 1'b0, 32'h0000_5000, 2'b10, 1'b0, 32'h0, 0, 0, 1'b1, 32'h0BAD_0BAD);
        idleCycle("idle5");
        applyStimulus("addr_wait_store", 1'b1, 32'h0000_5102, 2'b01, 1'b0, 32'h1357_BEEF, 2, 1, 1'b0, 32'h0);
        idleCycle("idle6");

        // Reset while the next request sits in its address phase.
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_6000;
        req_size  = 2'b10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        hready    = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_nonseq", 32'(htrans), 32'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst    = 1'b0;
        hready = 1'b1;
        hrdata = 32'h7777_7777;
        @(negedge clk);
        exp_dmdata = 32'd0;
        exp_resp   = 1'b0;
        exp_misal  = 1'b0;
        checkOutput("rst_mid_htrans", 32'(htrans), 32'd0);
        checkOutput("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_mid_stall", 32'(lsu_stall), 32'd0);
        checkOutput("rst_mid_ready", 32'(req_ready), 32'd1);
        repeat (3) idleCycle("post_rst");

        for (int n = 0; n < 24; n++) begin
            applyStimulus($sformatf("rand%0d", n), 1'($urandom), $urandom, 2'($urandom), 1'($urandom),
                          $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                          ($urandom_range(0, 3) == 0), $urandom);
            idleCycle($sformatf("rand_idle%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
